// File: rtl/mult_sequencer.sv
// Sequential 2*HALF x 2*HALF unsigned multiplier built from one shared HALF x HALF
// array multiplier slice, stepped over four cycles with a valid/ready handshake on both sides.

// Combinational unsigned array multiplier: shift-and-add of partial products.
module multiplier #(
  parameter int bits = 8
) (
  input  logic [bits-1:0]   a,
  input  logic [bits-1:0]   b,
  output logic [2*bits-1:0] p
);
  always_comb begin
    p = '0;
    for (int i = 0; i < bits; i++) begin
      if (b[i]) p = p + ({{bits{1'b0}}, a} << i);
    end
  end
endmodule

// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// in_ready is combinational from state and out_ready, out_valid/product come from registers.
module mult_sequencer #(
  parameter int HALF = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*HALF-1:0] a_in,
  input  logic [2*HALF-1:0] b_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*HALF-1:0] product
);
  localparam int W  = 2 * HALF;
  localparam int PW = 4 * HALF;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state, state_next;
  logic [1:0]      step;
  logic [PW-1:0]   acc;
  logic [W-1:0]    a_q, b_q;
  logic [HALF-1:0] mul_a, mul_b;
  logic [W-1:0]    mul_p;
  logic [PW-1:0]   partial;
  logic            accept;

  // Step selects which operand halves feed the shared slice and how far to shift.
  always_comb begin
    mul_a   = a_q[HALF-1:0];
    mul_b   = b_q[HALF-1:0];
    partial = '0;
    case (step)
      2'd0: begin
        mul_a = a_q[HALF-1:0]; mul_b = b_q[HALF-1:0];
        partial = PW'(mul_p);
      end
      2'd1: begin
        mul_a = a_q[HALF-1:0]; mul_b = b_q[W-1:HALF];
        partial = PW'(mul_p) << HALF;
      end
      2'd2: begin
        mul_a = a_q[W-1:HALF]; mul_b = b_q[HALF-1:0];
        partial = PW'(mul_p) << HALF;
      end
      default: begin
        mul_a = a_q[W-1:HALF]; mul_b = b_q[W-1:HALF];
        partial = PW'(mul_p) << W;
      end
    endcase
  end

  multiplier #(.bits(HALF)) u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MUL;
      end
      MUL: begin
        if (step == 2'd3) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready   = 1'b1;
          state_next = in_valid ? MUL : IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign accept  = in_valid && in_ready;
  assign product = acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      step  <= '0;
      acc   <= '0;
      a_q   <= '0;
      b_q   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_q  <= a_in;
        b_q  <= b_in;
        acc  <= '0;
        step <= '0;
      end else if (state == MUL) begin
        acc  <= acc + partial;
        step <= step + 2'd1;
      end
    end
  end
endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer (HALF=8): directed scenarios plus a randomized
// run checked against a cycle-counting reference model of the handshake and a*b.
module tb_mult_sequencer;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_in;
  logic [15:0] b_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] product;

  int checks = 0;
  int errors = 0;

  mult_sequencer #(.HALF(HALF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .product   (product)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver: offer one operand pair, then wait (bounded) for out_valid.
  // lat counts cycles from the accept cycle (C0) to the first out_valid cycle.
  task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                       output logic [31:0] p, output int lat, output bit mul_bad);
    in_valid = 1'b1;
    a_in     = a;
    b_in     = b;
    mul_bad  = 1'b0;
    tick();
    in_valid = 1'b0;
    lat      = 1;
    while (out_valid !== 1'b1 && lat < 20) begin
      if (in_ready !== 1'b0) mul_bad = 1'b1;
      in_valid = 1'($urandom_range(0, 1));
      a_in     = 16'($urandom);
      b_in     = 16'($urandom);
      tick();
      lat++;
    end
    in_valid = 1'b0;
    p = product;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a_in = '0; b_in = '0;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 32'h0) begin
      errors++;
      $display("FAIL reset: out_valid=%b in_ready=%b product=%h, required 0 1 00000000",
               out_valid, in_ready, product);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] p; int lat; bit bad;
    out_ready = 1'b1;
    do_op(16'h1234, 16'h5678, p, lat, bad);
    checks++;
    if (lat !== 5) begin
      errors++; $display("FAIL basic_latency: got %0d, required 5", lat);
    end
    checks++;
    if (p !== 32'h06260060) begin
      errors++; $display("FAIL basic_product: got %h, required 06260060", p);
    end
    checks++;
    if (bad) begin
      errors++; $display("FAIL basic_mul_ready: in_ready was 1 during MUL, required 0");
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_idle: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_full_carry();
    logic [31:0] p; int lat; bit bad;
    out_ready = 1'b1;
    do_op(16'hFFFF, 16'hFFFF, p, lat, bad);
    checks++;
    if (p !== 32'hFFFE0001 || lat !== 5) begin
      errors++; $display("FAIL full_carry: got %h lat %0d, required fffe0001 lat 5", p, lat);
    end
    tick();
  endtask

  task automatic test_zero_one();
    logic [31:0] p; int lat; bit bad;
    out_ready = 1'b1;
    do_op(16'h0000, 16'hBEEF, p, lat, bad);
    checks++;
    if (p !== 32'h00000000 || lat !== 5) begin
      errors++; $display("FAIL zero_operand: got %h lat %0d, required 00000000 lat 5", p, lat);
    end
    tick();
    do_op(16'h0001, 16'hBEEF, p, lat, bad);
    checks++;
    if (p !== 32'h0000BEEF || lat !== 5) begin
      errors++; $display("FAIL one_operand: got %h lat %0d, required 0000beef lat 5", p, lat);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] p; int lat; bit bad;
    out_ready = 1'b0;
    do_op(16'hABCD, 16'h0002, p, lat, bad);
    checks++;
    if (p !== 32'h0001579A || lat !== 5) begin
      errors++; $display("FAIL stall_product: got %h lat %0d, required 0001579a lat 5", p, lat);
    end
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      a_in     = 16'($urandom);
      b_in     = 16'($urandom);
      #1;
      checks++;
      if (out_valid !== 1'b1 || product !== 32'h0001579A || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d]: out_valid=%b product=%h in_ready=%b, required 1 0001579a 0",
                 i, out_valid, product, in_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_in      = 16'h0100;
    b_in      = 16'h0100;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL b2b_ready: in_ready=%b, required 1", in_ready);
    end
    do_op(16'h0100, 16'h0100, p, lat, bad);
    checks++;
    if (p !== 32'h00010000 || lat !== 5 || bad) begin
      errors++;
      $display("FAIL b2b_product: got %h lat %0d mul_bad %0d, required 00010000 lat 5 mul_bad 0",
               p, lat, bad);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [31:0] p; int lat; bit bad;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_in      = 16'hFFFF;
    b_in      = 16'hFFFF;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || product !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid: out_valid=%b in_ready=%b product=%h, required 0 1 00000000",
               out_valid, in_ready, product);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || product !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold[%0d]: out_valid=%b product=%h, required 0 00000000",
                 i, out_valid, product);
      end
    end
    rst = 1'b0;
    do_op(16'h0003, 16'h0005, p, lat, bad);
    checks++;
    if (p !== 32'h0000000F || lat !== 5) begin
      errors++; $display("FAIL after_reset: got %h lat %0d, required 0000000f lat 5", p, lat);
    end
    tick();
  endtask

  // Scoreboard: each accepted pair queues a*b and its accept cycle; a result is due
  // five cycles after its accept and stays offered until out_ready takes it.
  task automatic test_random();
    logic [31:0] exp_q[$];
    int          cyc_q[$];
    int          cyc    = 0;
    int          done_n = 0;
    bit          done_exp, fire_in, fire_out;
    logic [31:0] a32, b32;
    while (done_n < 2000 && cyc < 40000) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      out_ready = ($urandom_range(0, 99) < 70);
      a_in      = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      b_in      = ($urandom_range(0, 9) == 0) ? 16'hFFFF : 16'($urandom);
      #1;
      done_exp = (exp_q.size() > 0) && (cyc >= cyc_q[0] + 5);
      checks++;
      if (out_valid !== done_exp) begin
        errors++; $display("FAIL rand_out_valid cyc %0d: got %b, required %b", cyc, out_valid, done_exp);
      end
      fire_out = done_exp && out_ready;
      fire_in  = in_valid && (exp_q.size() == 0 || fire_out);
      checks++;
      if (in_ready !== (exp_q.size() == 0 || fire_out)) begin
        errors++;
        $display("FAIL rand_in_ready cyc %0d: got %b, required %b", cyc, in_ready,
                 (exp_q.size() == 0 || fire_out));
      end
      if (done_exp) begin
        checks++;
        if (product !== exp_q[0]) begin
          errors++; $display("FAIL rand_product cyc %0d: got %h, required %h", cyc, product, exp_q[0]);
        end
      end
      a32 = {16'h0, a_in};
      b32 = {16'h0, b_in};
      @(posedge clk);
      if (fire_out) begin
        void'(exp_q.pop_front());
        void'(cyc_q.pop_front());
        done_n++;
      end
      if (fire_in) begin
        exp_q.push_back(a32 * b32);
        cyc_q.push_back(cyc);
      end
      cyc++;
      #1;
    end
    checks++;
    if (done_n < 2000) begin
      errors++; $display("FAIL rand_budget: completed %0d operations, required 2000", done_n);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_carry();
    test_zero_one();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
